// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bus: the request/ack inputs and the registered reset/status
// outputs shared between the sequencer and the rest of the reset tree.
interface rst_seq_ctrl_if #(
  parameter int DOMAINS = 2
);
  logic               RST_REQ;
  logic [DOMAINS-1:0] DOM_ACK;
  logic [DOMAINS-1:0] DOM_RST_N;
  logic               BUSY;
  logic               DONE;
  logic               ACK_ERR;

  // The sequencer side.
  modport master (
    input  RST_REQ,
    input  DOM_ACK,
    output DOM_RST_N,
    output BUSY,
    output DONE,
    output ACK_ERR
  );

  // The surrounding system: reset requester and per-domain synchronizers.
  modport slave (
    output RST_REQ,
    output DOM_ACK,
    input  DOM_RST_N,
    input  BUSY,
    input  DONE,
    input  ACK_ERR
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts every domain reset, holds it, then releases domains
// in index order, waiting for each domain's synchronized ack before the next.
module rst_seq_ctrl #(
  parameter int DOMAINS     = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RST,
  rst_seq_ctrl_if.master bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DOMAINS-1:0] ack_meta_q, ack_s_q;
  logic [DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               ack_cur;

  // Ack of the domain currently being released, taken from the synchronized copy.
  assign ack_cur = ack_s_q[idx_q];

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        if (bus.RST_REQ) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (bus.RST_REQ) begin
          state_d = ST_ASSERT;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (ack_cur || (cnt_q == ACK_LAST)) begin
          // A timeout advances exactly like an ack but leaves a sticky error.
          if (!ack_cur) ack_err_d = 1'b1;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.RST_REQ) begin
          state_d = ST_ASSERT;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state and leave the block straight from flops.
  always_comb begin
    dom_rst_n_d = '0;
    busy_d      = (state_d != ST_RUN);
    if (state_d == ST_RUN) begin
      dom_rst_n_d = '1;
    end else if (state_d == ST_RELEASE) begin
      for (int j = 0; j < DOMAINS; j++) begin
        dom_rst_n_d[j] = (j <= int'(idx_d));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      ack_meta_q  <= '0;
      ack_s_q     <= '0;
      dom_rst_n_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ack_meta_q  <= bus.DOM_ACK;
      ack_s_q     <= ack_meta_q;
      dom_rst_n_q <= dom_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
    end
  end

  assign bus.DOM_RST_N = dom_rst_n_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ACK_ERR   = ack_err_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed reset-sequence scenarios with literal
// expectations, then randomized requests/acks against a count-based model.
module tb_rst_seq_ctrl;

  localparam int DOMAINS     = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int VW          = DOMAINS + 3;

  logic CLK = 1'b0;
  logic RST;

  rst_seq_ctrl_if #(.DOMAINS(DOMAINS)) bus ();

  rst_seq_ctrl #(
    .DOMAINS    (DOMAINS),
    .HOLD_CYCLES(HOLD_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Domain responder: each domain acks its reset release dly[d] cycles later
  // unless held low by stuck[d].
  int                 dly [DOMAINS];
  logic [DOMAINS-1:0] stuck;

  initial begin
    logic [DOMAINS-1:0] hist [8];
    logic [DOMAINS-1:0] a;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    bus.DOM_ACK = '0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.DOM_RST_N;
      a = '0;
      for (int d = 0; d < DOMAINS; d++) a[d] = stuck[d] ? 1'b0 : hist[dly[d]][d];
      bus.DOM_ACK = a;
    end
  end

  // Reference model: number of released domains, cycles spent in the current
  // wait, and the two-sample delay the ack synchronizer introduces.
  int                 m_rel  = 0;
  int                 m_cnt  = 0;
  bit                 m_run  = 1'b0;
  bit                 m_done = 1'b0;
  bit                 m_err  = 1'b0;
  logic [DOMAINS-1:0] m_meta = '0;
  logic [DOMAINS-1:0] m_acks = '0;
  logic [DOMAINS-1:0] acks_now;

  always @(posedge CLK) begin
    acks_now = m_acks;
    if (RST) begin
      m_rel = 0; m_cnt = 0; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_meta = '0; m_acks = '0;
    end else begin
      m_acks = m_meta;
      m_meta = bus.DOM_ACK;
      m_done = 1'b0;
      if (m_run) begin
        if (bus.RST_REQ) begin
          m_run = 1'b0; m_rel = 0; m_cnt = 0;
        end
      end else if (m_rel == 0) begin
        if (bus.RST_REQ) m_cnt = 0;
        else if (m_cnt == HOLD_CYCLES - 1) begin
          m_rel = 1; m_cnt = 0;
        end else m_cnt++;
      end else begin
        if (bus.RST_REQ) begin
          m_rel = 0; m_cnt = 0;
        end else if (acks_now[m_rel-1] || m_cnt == ACK_TIMEOUT - 1) begin
          if (!acks_now[m_rel-1]) m_err = 1'b1;
          m_cnt = 0;
          if (m_rel == DOMAINS) begin
            m_run = 1'b1; m_done = 1'b1;
          end else m_rel++;
        end else m_cnt++;
      end
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [DOMAINS-1:0] dom;
    dom = m_run ? '1 : DOMAINS'((1 << m_rel) - 1);
    return {dom, !m_run, m_done, m_err};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.DOM_RST_N, bus.BUSY, bus.DONE, bus.ACK_ERR};
  endfunction

  always @(negedge CLK) begin
    if (chk_en) check("model_cmp", 32'(dut_vec()), 32'(model_vec()));
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Literal expectation {DOM_RST_N, BUSY, DONE, ACK_ERR}, applied to DUT and model.
  task automatic expect_out(input string name, input logic [VW-1:0] e);
    @(negedge CLK);
    check(name, 32'(dut_vec()), 32'(e));
    check({name, "_model"}, 32'(model_vec()), 32'(e));
  endtask

  task automatic pulse_req();
    bus.RST_REQ = 1'b1;
    step(1);
    bus.RST_REQ = 1'b0;
  endtask

  initial begin
    RST         = 1'b1;
    bus.RST_REQ = 1'b0;
    stuck       = '0;
    dly[0]      = 2;
    dly[1]      = 2;
    step(3);
    chk_en = 1'b1;
    RST    = 1'b0;

    // 1: power-on sequence
    expect_out("t1_reset",     5'b00100);
    step(3); expect_out("t1_hold_end",  5'b00100);
    step(1); expect_out("t1_rel0",      5'b01100);
    step(4); expect_out("t1_rel0_wait", 5'b01100);
    step(1); expect_out("t1_rel1",      5'b11100);
    step(4); expect_out("t1_rel1_wait", 5'b11100);
    step(1); expect_out("t1_done",      5'b11010);
    step(1); expect_out("t1_run",       5'b11000);

    // 2: single-cycle request from RUN repeats the sequence
    pulse_req();
    expect_out("t2_assert", 5'b00100);
    step(4);  expect_out("t2_rel0", 5'b01100);
    step(10); expect_out("t2_done", 5'b11010);

    // 3: domain 1 never acks -> timeout, sticky error
    stuck = 2'b10;
    pulse_req();
    step(16); expect_out("t3_wait",    5'b11100);
    step(1);  expect_out("t3_timeout", 5'b11011);
    stuck = '0;
    pulse_req();
    expect_out("t3_sticky", 5'b00101);
    step(14); expect_out("t3_rerun", 5'b11011);

    // 4: abort while releasing domain 1
    pulse_req();
    step(9); expect_out("t4_rel1", 5'b11101);
    pulse_req();
    expect_out("t4_abort", 5'b00101);
    step(3);  expect_out("t4_hold_end", 5'b00101);
    step(1);  expect_out("t4_rel0",     5'b01101);
    step(10); expect_out("t4_done",     5'b11011);

    // 5: request held for 20 cycles
    bus.RST_REQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      expect_out("t5_held", 5'b00101);
    end
    bus.RST_REQ = 1'b0;
    step(3); expect_out("t5_hold_end", 5'b00101);
    step(1); expect_out("t5_rel0",     5'b01101);

    // 6: RST mid-release
    RST = 1'b1;
    step(1);
    expect_out("t6_reset", 5'b00100);
    check("t6_ack_s_clr", 32'(dut.ack_s_q), 32'd0);
    check("t6_idx_clr",   32'(dut.idx_q),   32'd0);
    RST = 1'b0;

    // Randomized requests, resets, ack delays and stuck acks
    for (int c = 0; c < 4000; c++) begin
      step(1);
      if (RST) RST = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 299) == 0) RST = 1'b1;
      if (bus.RST_REQ) bus.RST_REQ = ($urandom_range(0, 3) != 0);
      else bus.RST_REQ = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) stuck = DOMAINS'($urandom_range(0, (1 << DOMAINS) - 1));
      if ($urandom_range(0, 49) == 0) begin
        for (int d = 0; d < DOMAINS; d++) dly[d] = $urandom_range(1, 6);
      end
    end

    step(1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
